// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that sequences single LOAD/STORE transactions onto the
// data-memory port, with timeout and misaligned-address error responses.
package simple_processor_pkg;
    localparam int DATA_WIDTH = 32;
endpackage

module mem_arbiter
    import simple_processor_pkg::*;
#(
    parameter int TIMEOUT_CYCLES   = 16,
    parameter bit ADDR_ALIGN_CHECK = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,

    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic                  req0_we_i,
    input  logic [DATA_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_wdata_i,
    output logic                  rsp0_valid_o,
    output logic [DATA_WIDTH-1:0] rsp0_rdata_o,
    output logic                  rsp0_err_o,

    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic                  req1_we_i,
    input  logic [DATA_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_wdata_i,
    output logic                  rsp1_valid_o,
    output logic [DATA_WIDTH-1:0] rsp1_rdata_o,
    output logic                  rsp1_err_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_RESP
    } state_t;

    state_t                state;
    logic                  port_q;
    logic                  last_grant;
    logic                  we_q;
    logic                  mem_req_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [CNT_W-1:0]      cnt;

    logic                  any_valid;
    logic                  sel;
    logic                  accept;
    logic                  sel_we;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  misaligned;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  timeout_hit;

    // Selection: a lone requester wins; on a tie the port not served last time wins.
    always_comb begin
        any_valid   = req0_valid_i | req1_valid_i;
        sel         = (req0_valid_i && req1_valid_i) ? ~last_grant : req1_valid_i;
        accept      = arst_ni && (state == S_IDLE) && any_valid;
        sel_we      = sel ? req1_we_i    : req0_we_i;
        sel_addr    = sel ? req1_addr_i  : req0_addr_i;
        sel_wdata   = sel ? req1_wdata_i : req0_wdata_i;
        misaligned  = ADDR_ALIGN_CHECK && (sel_addr[1:0] != 2'b00);
        cnt_inc     = cnt + CNT_W'(1);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    end

    assign req0_ready_o = accept & ~sel;
    assign req1_ready_o = accept &  sel;

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_req_q & we_q;
    assign mem_addr_o  = mem_req_q ? addr_q  : '0;
    assign mem_wdata_o = mem_req_q ? wdata_q : '0;

    // port_q only changes in IDLE, while the response registers are already cleared.
    assign rsp0_valid_o = rsp_valid_q & ~port_q;
    assign rsp1_valid_o = rsp_valid_q &  port_q;
    assign rsp0_err_o   = rsp_err_q   & ~port_q;
    assign rsp1_err_o   = rsp_err_q   &  port_q;
    assign rsp0_rdata_o = port_q ? '0 : rsp_rdata_q;
    assign rsp1_rdata_o = port_q ? rsp_rdata_q : '0;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state       <= S_IDLE;
            port_q      <= 1'b0;
            last_grant  <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (any_valid) begin
                        port_q  <= sel;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        if (misaligned) begin
                            state       <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state     <= S_ISSUE;
                            mem_req_q <= 1'b1;
                        end
                    end
                end

                // A grant that completes a store beats a coincident timeout.
                S_ISSUE: begin
                    cnt <= cnt_inc;
                    if (mem_gnt_i && we_q) begin
                        state       <= S_RESP;
                        mem_req_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end else if (timeout_hit) begin
                        state       <= S_RESP;
                        mem_req_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else if (mem_gnt_i) begin
                        state     <= S_WAIT_RSP;
                        mem_req_q <= 1'b0;
                    end
                end

                S_WAIT_RSP: begin
                    cnt <= cnt_inc;
                    if (mem_rvalid_i) begin
                        state       <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= mem_rdata_i;
                    end else if (timeout_hit) begin
                        state       <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end
                end

                S_RESP: begin
                    state       <= S_IDLE;
                    cnt         <= '0;
                    last_grant  <= port_q;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end

                default: begin
                    state     <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model that predicts winner, latency, memory activity and response.
module tb_mem_arbiter;

    localparam int TO    = 16;
    localparam int NEVER = 99;

    logic        clk = 1'b0;
    logic        arst_ni = 1'b0;
    logic        req0_valid_i = 1'b0, req0_we_i = 1'b0;
    logic [31:0] req0_addr_i = '0, req0_wdata_i = '0;
    logic        req1_valid_i = 1'b0, req1_we_i = 1'b0;
    logic [31:0] req1_addr_i = '0, req1_wdata_i = '0;
    logic        req0_ready_o, req1_ready_o;
    logic        rsp0_valid_o, rsp1_valid_o, rsp0_err_o, rsp1_err_o;
    logic [31:0] rsp0_rdata_o, rsp1_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    mem_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_ALIGN_CHECK(1'b1)) dut (
        .clk_i(clk), .arst_ni(arst_ni),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
        .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_rdata_o(rsp0_rdata_o), .rsp0_err_o(rsp0_err_o),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
        .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_rdata_o(rsp1_rdata_o), .rsp1_err_o(rsp1_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester-side model: pending request per port and the port served last.
    logic        pv     [2];
    logic        pwe    [2];
    logic [31:0] paddr  [2];
    logic [31:0] pwdata [2];
    int          last_served = 1;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, " mem_req"}, mem_req_o, 1'b0);
        chk1({tag, " mem_we"}, mem_we_o, 1'b0);
        chk32({tag, " mem_addr"}, mem_addr_o, 32'h0);
        chk32({tag, " mem_wdata"}, mem_wdata_o, 32'h0);
        chk1({tag, " rsp0_valid"}, rsp0_valid_o, 1'b0);
        chk1({tag, " rsp1_valid"}, rsp1_valid_o, 1'b0);
        chk1({tag, " rsp0_err"}, rsp0_err_o, 1'b0);
        chk1({tag, " rsp1_err"}, rsp1_err_o, 1'b0);
        chk32({tag, " rsp0_rdata"}, rsp0_rdata_o, 32'h0);
        chk32({tag, " rsp1_rdata"}, rsp1_rdata_o, 32'h0);
        chk1({tag, " ready0"}, req0_ready_o, 1'b0);
        chk1({tag, " ready1"}, req1_ready_o, 1'b0);
    endtask

    task automatic set_req(input int q, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        pv[q] = 1'b1; pwe[q] = we; paddr[q] = addr; pwdata[q] = wdata;
    endtask

    task automatic rand_req(input int q);
        logic [31:0] a;
        a = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        set_req(q, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    task automatic drive_reqs();
        req0_valid_i = pv[0]; req0_we_i = pwe[0]; req0_addr_i = paddr[0]; req0_wdata_i = pwdata[0];
        req1_valid_i = pv[1]; req1_we_i = pwe[1]; req1_addr_i = paddr[1]; req1_wdata_i = pwdata[1];
    endtask

    // d: cycles the grant is withheld in ISSUE; r: cycles from WAIT_RSP entry to rvalid.
    task automatic do_txn(input int d, input int r, input logic [31:0] rd);
        int p, lat, req_end;
        logic mis, err;
        logic [31:0] data;
        p   = (pv[0] && pv[1]) ? 1 - last_served : (pv[1] ? 1 : 0);
        mis = (paddr[p][1:0] != 2'b00);
        if (mis) begin
            lat = 1; err = 1'b1; data = '0; req_end = 0;
        end else begin
            req_end = (d < TO) ? d + 1 : TO;
            data = '0;
            if (pwe[p]) begin
                if (d < TO) begin lat = d + 2; err = 1'b0; end
                else begin lat = TO + 1; err = 1'b1; end
            end else if (d < TO && d + r + 2 <= TO) begin
                lat = d + r + 3; err = 1'b0; data = rd;
            end else begin
                lat = TO + 1; err = 1'b1;
            end
        end

        @(negedge clk);
        drive_reqs();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        chk1("accept ready0", req0_ready_o, p == 0);
        chk1("accept ready1", req1_ready_o, p == 1);
        chk1("accept mem_req", mem_req_o, 1'b0);
        @(posedge clk);
        pv[p] = 1'b0;

        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            drive_reqs();
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            #1;
            chk1("busy ready0", req0_ready_o, 1'b0);
            chk1("busy ready1", req1_ready_o, 1'b0);
            chk1("mem_req", mem_req_o, c <= req_end);
            if (c <= req_end) begin
                chk32("mem_addr", mem_addr_o, paddr[p]);
                chk1("mem_we", mem_we_o, pwe[p]);
                if (pwe[p]) chk32("mem_wdata", mem_wdata_o, pwdata[p]);
            end
            chk1("rsp0_valid", rsp0_valid_o, (c == lat) && (p == 0));
            chk1("rsp1_valid", rsp1_valid_o, (c == lat) && (p == 1));
            if (c == lat) begin
                chk32("rsp rdata", p ? rsp1_rdata_o : rsp0_rdata_o, data);
                chk1("rsp err", p ? rsp1_err_o : rsp0_err_o, err);
                chk32("other rdata", p ? rsp0_rdata_o : rsp1_rdata_o, 32'h0);
                chk1("other err", p ? rsp0_err_o : rsp1_err_o, 1'b0);
            end
            if (!mis) begin
                mem_gnt_i = (c == d + 1);
                if (!pwe[p]) begin
                    if (d < TO && c == d + 2 + r) begin
                        mem_rvalid_i = 1'b1; mem_rdata_i = rd;
                    end else if (c <= d + 1) begin
                        mem_rvalid_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
                    end
                end
            end
            @(posedge clk);
        end
        last_served = p;
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && (pv[0] || pv[1]); k++) do_txn(0, 0, $urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, r;
        pv[0] = 1'b0; pv[1] = 1'b0;
        pwe[0] = 1'b0; pwe[1] = 1'b0;
        paddr[0] = '0; paddr[1] = '0;
        pwdata[0] = '0; pwdata[1] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        arst_ni = 1'b1;

        // Both ports always requesting stores: grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            if (!pv[0]) set_req(0, 1'b1, 32'h0000_0100 + 32'(i * 4), 32'hA000_0000 + 32'(i));
            if (!pv[1]) set_req(1, 1'b1, 32'h0000_0200 + 32'(i * 4), 32'hB000_0000 + 32'(i));
            do_txn(0, 0, 32'h0);
        end
        drain();

        // Port 0 load, immediate grant, rvalid next cycle.
        set_req(0, 1'b0, 32'h0000_0010, 32'h0);
        do_txn(0, 0, 32'hDEAD_BEEF);

        // Port 1 store with the grant withheld 5 cycles.
        set_req(1, 1'b1, 32'h0000_0020, 32'h1234_5678);
        do_txn(5, 0, 32'h0);

        // Load whose data never arrives, then a normal store.
        set_req(0, 1'b0, 32'h0000_0040, 32'h0);
        do_txn(0, NEVER, 32'h5555_AAAA);
        set_req(0, 1'b1, 32'h0000_0044, 32'hA5A5_5A5A);
        do_txn(0, 0, 32'h0);

        // Misaligned load, and rvalid landing exactly on the last allowed cycle.
        set_req(0, 1'b0, 32'h0000_0013, 32'h0);
        do_txn(0, 0, 32'h0);
        set_req(1, 1'b0, 32'h0000_0048, 32'h0);
        do_txn(10, 4, 32'hCAFE_F00D);

        // Reset while waiting for read data.
        set_req(0, 1'b0, 32'h0000_0080, 32'h0);
        @(negedge clk); drive_reqs(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        @(posedge clk); pv[0] = 1'b0;
        @(negedge clk); drive_reqs(); mem_gnt_i = 1'b1;
        @(posedge clk);
        @(negedge clk); mem_gnt_i = 1'b0;
        #1;
        chk1("wait mem_req", mem_req_o, 1'b0);
        arst_ni = 1'b0;
        #1;
        chk_all_zero("reset in wait");
        @(posedge clk);
        @(negedge clk);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BAD_0BAD;
        arst_ni = 1'b1;
        last_served = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk); #1;
            chk1("post-reset rsp0_valid", rsp0_valid_o, 1'b0);
            chk1("post-reset rsp1_valid", rsp1_valid_o, 1'b0);
            chk1("post-reset mem_req", mem_req_o, 1'b0);
        end
        mem_rvalid_i = 1'b0;
        set_req(0, 1'b1, 32'h0000_0090, 32'h1111_0000);
        set_req(1, 1'b1, 32'h0000_0094, 32'h2222_0000);
        do_txn(0, 0, 32'h0);
        drain();

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            for (int q = 0; q < 2; q++)
                if (!pv[q] && $urandom_range(0, 9) < 6) rand_req(q);
            if (!pv[0] && !pv[1]) rand_req(int'($urandom_range(0, 1)));
            d = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 10));
            r = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 4));
            do_txn(d, r, $urandom);
        end
        drain();

        // Reset while a request is being presented to memory.
        set_req(1, 1'b1, 32'h0000_0084, 32'h7777_8888);
        @(negedge clk); drive_reqs(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        chk1("issue-reset ready1", req1_ready_o, 1'b1);
        @(posedge clk); pv[1] = 1'b0;
        @(negedge clk); drive_reqs();
        #1;
        chk1("issue mem_req", mem_req_o, 1'b1);
        arst_ni = 1'b0;
        #1;
        chk_all_zero("reset in issue");
        @(posedge clk);
        @(negedge clk);
        arst_ni = 1'b1;
        last_served = 1;
        set_req(0, 1'b0, 32'h0000_00A0, 32'h0);
        set_req(1, 1'b0, 32'h0000_00A4, 32'h0);
        do_txn(1, 2, 32'h3C3C_C3C3);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
